// File: rtl/mult_pkg.sv
// Shared definitions for the add-shift multiplier: sequencer state encoding
// and the operand width used by the datapath registers.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } mult_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Ports: clk, rst (async active-high, clears both flops), d (async in), q (synchronized out).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the input through the two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mult_ctrl_fsm.sv
// Sequencer for the 8-bit add-shift multiplier datapath. One multiplication
// per Execute press: clear A, then WIDTH add/shift pairs (subtract on the
// final iteration), then hold with Done until Execute is released.
// Optional build macro MULT_CTRL_SYNC_EN: Execute and ClearA_loadB pass
// through two-flop synchronizers (M is always used directly).
// Ports:
//   Clk, Reset (async active-high)
//   Execute, ClearA_loadB : button levels
//   M                     : current multiplier LSB (register B bit 0)
//   Clr_Ld, ClearA, Add_en, Sub_en, Shift_en : one-cycle datapath strobes
//   Busy                  : high from CLR through the last SHIFT
//   Done                  : high in HOLD
module mult_ctrl_fsm
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Execute,
    input  logic ClearA_loadB,
    input  logic M,
    output logic Clr_Ld,
    output logic ClearA,
    output logic Add_en,
    output logic Sub_en,
    output logic Shift_en,
    output logic Busy,
    output logic Done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

    logic exec_s;
    logic load_s;

`ifdef MULT_CTRL_SYNC_EN
    sync_2ff u_sync_exec (
        .clk (Clk),
        .rst (Reset),
        .d   (Execute),
        .q   (exec_s)
    );

    sync_2ff u_sync_load (
        .clk (Clk),
        .rst (Reset),
        .d   (ClearA_loadB),
        .q   (load_s)
    );
`else
    assign exec_s = Execute;
    assign load_s = ClearA_loadB;
`endif

    mult_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic clr_ld_c, clear_a_c, add_en_c, sub_en_c, shift_en_c, busy_c, done_c;

    // State and iteration counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and strobes; add/sub strobes are Mealy on M.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_ld_c   = 1'b0;
        clear_a_c  = 1'b0;
        add_en_c   = 1'b0;
        sub_en_c   = 1'b0;
        shift_en_c = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            IDLE: begin
                // Load request has priority over starting a multiply.
                if (load_s) begin
                    clr_ld_c = 1'b1;
                end else if (exec_s) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                clear_a_c = 1'b1;
                busy_c    = 1'b1;
                cnt_d     = '0;
                state_d   = ADD;
            end
            ADD: begin
                busy_c = 1'b1;
                // The sign bit of the multiplier carries negative weight.
                if (cnt_q == LAST_IT) begin
                    sub_en_c = M;
                end else begin
                    add_en_c = M;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                busy_c     = 1'b1;
                shift_en_c = 1'b1;
                if (cnt_q == LAST_IT) begin
                    state_d = HOLD;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ADD;
                end
            end
            HOLD: begin
                done_c = 1'b1;
                if (!exec_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Mask everything while Reset is asserted so a held load button
    // cannot leak a strobe through the combinational IDLE path.
    assign Clr_Ld   = clr_ld_c   & ~Reset;
    assign ClearA   = clear_a_c  & ~Reset;
    assign Add_en   = add_en_c   & ~Reset;
    assign Sub_en   = sub_en_c   & ~Reset;
    assign Shift_en = shift_en_c & ~Reset;
    assign Busy     = busy_c     & ~Reset;
    assign Done     = done_c     & ~Reset;

endmodule

// File: doc/mult_ctrl_fsm.md
Name: mult_ctrl_fsm

Overview:
Sequencer that drives the 8-bit add-shift multiplier datapath (9-bit A register, 8-bit B register, 9-bit add/sub unit).
- Takes the board-level Execute and ClearA_loadB buttons plus the multiplier LSB from register B.
- Issues one-cycle clear, load, add, subtract and shift strobes to the datapath.
- Runs exactly one multiplication per Execute press, then holds until the button is released.

Parameters:
- WIDTH, 8, multiplier bit count; equals the number of add/shift iterations.
- CNT_W, $clog2(WIDTH), iteration counter width (derived; do not override).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Execute  in  1  start request, level from button; active-high.
- ClearA_loadB  in  1  load request, level from button; active-high.
- M  in  1  current LSB of register B (multiplier bit under test).
- Clr_Ld  out  1  clear A and X, load B from switches.
- ClearA  out  1  clear A and X only, at start of a multiply.
- Add_en  out  1  load A with A + S (sign-extended to 9 bits).
- Sub_en  out  1  load A with A - S (final iteration only).
- Shift_en  out  1  arithmetic right shift of X:A:B by one.
- Busy  out  1  high from CLR through the last SHIFT inclusive.
- Done  out  1  high in HOLD.

Behaviour:
- Async Reset -> state IDLE, counter 0. All outputs are 0 during and immediately after reset.
- Reset asserted mid-operation aborts the multiply. No further strobes are issued.
- States: IDLE, CLR, ADD, SHIFT, HOLD. Encoding comes from the package enum.
- IDLE:
  - ClearA_loadB=1 -> Clr_Ld=1 (combinational, every cycle it is held); stay IDLE.
  - Else Execute=1 -> next CLR.
  - Both high in the same cycle: ClearA_loadB wins; no multiply starts.
- CLR: ClearA=1, counter <= 0, next ADD.
- ADD: Add/Sub strobes are Mealy on M.
  - Counter < WIDTH-1: Add_en = M, Sub_en = 0.
  - Counter == WIDTH-1: Sub_en = M, Add_en = 0.
  - Next SHIFT.
- SHIFT: Shift_en=1.
  - Counter == WIDTH-1 -> next HOLD.
  - Else counter += 1, next ADD.
- HOLD: Done=1. Execute=0 -> next IDLE. Execute=1 -> remain in HOLD; no retrigger.
- At most one of Clr_Ld, ClearA, Add_en, Sub_en, Shift_en is high in any cycle.
- Latency: Execute sampled high in IDLE at edge 0 gives:
  - ClearA in cycle 1.
  - ADD/SHIFT pairs in cycles 2..17.
  - Done from cycle 18.
  - Total 2*WIDTH+1 active cycles.
- ClearA_loadB is ignored outside IDLE.
- Execute released mid-run does not abort the run. The FSM completes to HOLD, then goes to IDLE one cycle later.
- Counter never wraps within a run; it is reset in CLR.

Optional Feature:
MULT_CTRL_SYNC_EN
- Defined:
  - Execute and ClearA_loadB each pass through a two-flop synchronizer before use.
  - Synchronizer flops reset to 0 on Reset.
  - All input-to-state latencies grow by 2 cycles; M is not synchronized.
- Undefined: inputs are used directly; latencies as above.

Decomposition:
- Package mult_pkg holds:
  - State enum mult_state_e {IDLE, CLR, ADD, SHIFT, HOLD}.
  - Localparam MULT_WIDTH = 8, shared with the datapath registers.
- One sub-module: sync_2ff (1-bit, async active-high reset).
  - Instantiated twice, only under MULT_CTRL_SYNC_EN.

Test Plan:
- Reset then ClearA_loadB=1 for 3 cycles -> Clr_Ld high exactly those 3 cycles; Busy=0; all other strobes 0.
- Execute pulse held 30 cycles, M tied 1 -> ClearA in cycle 1; Add_en in ADD for iterations 0..6; Sub_en in iteration 7; 8 Shift_en pulses; Done from cycle 18 while Execute held; IDLE one cycle after release.
- Datapath model with S=0x07 (7), B=0xFD (-3), M driven from the model -> final A:B = 0xFFEB (-21).
- Execute and ClearA_loadB high in the same IDLE cycle -> Clr_Ld=1, no ClearA, state stays IDLE.
- Reset asserted in the ADD state of iteration 4 -> all outputs 0 immediately (async); IDLE on release; next Execute gives a full 17-cycle run.
- With MULT_CTRL_SYNC_EN, Execute rise -> ClearA at cycle 3 instead of 1; without the macro, cycle 1.
